// File: rtl/addmin_rr_sched_if.sv
// Command/response bundle for addmin_rr_sched: per-requester command channels
// plus the single tagged response channel.
interface addmin_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_p1;
    logic [N_REQ*WIDTH-1:0] req_p2;
    logic [N_REQ-1:0]       req_type;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_result;
    logic                   rsp_carry;
    logic [IDW-1:0]         rsp_id;

    modport master (
        output req_valid, req_p1, req_p2, req_type, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_id
    );

    modport slave (
        input  req_valid, req_p1, req_p2, req_type, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_id
    );
endinterface

// File: rtl/addmin_rr_sched.sv
// Round-robin scheduler sharing one add / magnitude-subtract datapath among N_REQ requesters.
// Optional statistics counters are enabled by defining ADDMIN_RR_SCHED_STATS_EN.
module addmin_rr_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addmin_rr_sched_if.slave     bus
`ifdef ADDMIN_RR_SCHED_STATS_EN
    ,
    output logic [15:0]          op_count,
    output logic [15:0]          neg_count
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id;
    logic             grant_found;
    logic             req_fire;
    logic             rsp_fire;
    logic [WIDTH-1:0] cap_p1;
    logic [WIDTH-1:0] cap_p2;
    logic             cap_type;
    logic [IDW-1:0]   cap_id;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    // Index arithmetic modulo N_REQ, valid for non-power-of-two requester counts.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDW'(s);
    endfunction

    assign req_fire      = (state == IDLE) && grant_found;
    assign rsp_fire      = (state == RESP) && bus.rsp_ready;
    assign bus.rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Scanning downward lets the requester closest to rr_ptr overwrite the others.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[wrap_add(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant_id    = wrap_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (req_fire) bus.req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_p1   <= '0;
            cap_p2   <= '0;
            cap_type <= 1'b0;
            cap_id   <= '0;
        end else if (req_fire) begin
            cap_p1   <= bus.req_p1[grant_id*WIDTH +: WIDTH];
            cap_p2   <= bus.req_p2[grant_id*WIDTH +: WIDTH];
            cap_type <= bus.req_type[grant_id];
            cap_id   <= grant_id;
        end
    end

    always_comb begin
        sum = {1'b0, cap_p1} + {1'b0, cap_p2};
        if (cap_type) begin
            alu_result = sum[WIDTH-1:0];
            alu_carry  = sum[WIDTH];
        end else if (cap_p1 < cap_p2) begin
            alu_result = cap_p2 - cap_p1;
            alu_carry  = 1'b1;
        end else begin
            alu_result = cap_p1 - cap_p2;
            alu_carry  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_id     <= '0;
        end else if (state == EXEC) begin
            bus.rsp_result <= alu_result;
            bus.rsp_carry  <= alu_carry;
            bus.rsp_id     <= cap_id;
        end
    end

    // Fairness pointer moves only once the response is actually consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rr_ptr <= '0;
        else if (rsp_fire) rr_ptr <= wrap_add(bus.rsp_id, 1);
    end

`ifdef ADDMIN_RR_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count  <= '0;
            neg_count <= '0;
        end else if (rsp_fire) begin
            if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
            if (!cap_type && bus.rsp_carry && neg_count != 16'hFFFF)
                neg_count <= neg_count + 16'd1;
        end
    end
`endif

endmodule
